// File: rtl/sipo_rx_if.sv
// -----------------------------------------------------------------------------
// sipo_rx_if
// Bundles the 1-bit receive link and the parallel-word valid/ready handshake.
//   si        : serial data bit                     (link -> receiver)
//   si_valid  : si holds a bit to accept this cycle (link -> receiver)
//   si_sof    : this bit is bit 0 of a new word     (link -> receiver)
//   po        : assembled word                      (receiver -> consumer)
//   po_valid  : output buffer holds a word          (receiver -> consumer)
//   po_ready  : consumer takes the word             (consumer -> receiver)
// The master modport is the environment side; the slave modport is the receiver.
// -----------------------------------------------------------------------------
interface sipo_rx_if #(
  parameter int WIDTH = 4
);
  logic             si;
  logic             si_valid;
  logic             si_sof;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;

  modport master (
    output si, si_valid, si_sof, po_ready,
    input  po, po_valid
  );

  modport slave (
    input  si, si_valid, si_sof, po_ready,
    output po, po_valid
  );
endinterface

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx
// Serial-in, parallel-out receiver. Bits are sampled on the rising edge and
// shifted into sr; every WIDTH accepted bits a word is moved into a one-entry
// output buffer with a valid/ready handshake. si_sof realigns the bit counter.
// Ports:
//   clk      : clock, all state updates on the rising edge
//   rst      : synchronous active-high reset, highest priority
//   bus      : sipo_rx_if.slave (si, si_valid, si_sof, po, po_valid, po_ready)
//   busy     : a partial word is in the shift register
//   overrun  : sticky, a completed word was dropped because the buffer was full
//   ovr_clr  : clears overrun (a drop on the same cycle wins)
//   sof_err  : one-cycle pulse when si_sof discards a partial word
// -----------------------------------------------------------------------------
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  sipo_rx_if.slave    bus,
  output logic        busy,
  output logic        overrun,
  input  logic        ovr_clr,
  output logic        sof_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             overrun_q, overrun_d;
  logic             sof_err_q, sof_err_d;
  logic             complete_s;

  // Next-state: shift, count, word completion, buffer handshake and flags.
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = overrun_q;
    sof_err_d  = 1'b0;
    complete_s = 1'b0;

    if (bus.si_valid) begin
      if (LSB_FIRST != 0) begin
        sr_d = {bus.si, sr_q[WIDTH-1:1]};
      end else begin
        sr_d = {sr_q[WIDTH-2:0], bus.si};
      end

      // A start-of-frame bit is bit 0, so the count after it is always 1.
      if (bus.si_sof) begin
        cnt_d     = CW'(1);
        sof_err_d = (cnt_q != {CW{1'b0}});
      end else if (cnt_q == CNT_MAX) begin
        cnt_d      = {CW{1'b0}};
        complete_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end

    // Clear first so that a drop in the same cycle overrides it.
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    // The buffer can accept the new word if it is empty or is being drained now.
    if (complete_s) begin
      if (!po_valid_q || bus.po_ready) begin
        po_d       = sr_d;
        po_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (po_valid_q && bus.po_ready) begin
      po_valid_d = 1'b0;
    end else begin
      po_valid_d = po_valid_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= {WIDTH{1'b0}};
      cnt_q      <= {CW{1'b0}};
      po_q       <= {WIDTH{1'b0}};
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
      sof_err_q  <= sof_err_d;
    end
  end

  assign bus.po       = po_q;
  assign bus.po_valid = po_valid_q;
  assign busy         = (cnt_q != {CW{1'b0}});
  assign overrun      = overrun_q;
  assign sof_err      = sof_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx
// Drives the same directed bit stream into two receivers (LSB-first and
// MSB-first, WIDTH=4). A word-level model (list of received bits plus a
// one-entry buffer) predicts the outputs; a compare process checks both DUTs
// on every falling edge, and directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_sipo_rx;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic si = 1'b0, si_valid = 1'b0, si_sof = 1'b0, po_ready = 1'b0, ovr_clr = 1'b0;
  logic busy_l, ovr_l, sof_l, busy_m, ovr_m, sof_m;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  sipo_rx_if #(.WIDTH(W)) if_l ();
  sipo_rx_if #(.WIDTH(W)) if_m ();

  assign if_l.si = si;  assign if_l.si_valid = si_valid;
  assign if_l.si_sof = si_sof;  assign if_l.po_ready = po_ready;
  assign if_m.si = si;  assign if_m.si_valid = si_valid;
  assign if_m.si_sof = si_sof;  assign if_m.po_ready = po_ready;

  sipo_rx #(.WIDTH(W), .LSB_FIRST(1)) dut_l (
    .clk(clk), .rst(rst), .bus(if_l.slave),
    .busy(busy_l), .overrun(ovr_l), .ovr_clr(ovr_clr), .sof_err(sof_l)
  );

  sipo_rx #(.WIDTH(W), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst(rst), .bus(if_m.slave),
    .busy(busy_m), .overrun(ovr_m), .ovr_clr(ovr_clr), .sof_err(sof_m)
  );

  // ---------------- behavioural model ----------------
  bit         bits[W];
  int         m_cnt = 0;
  logic [W-1:0] m_po_l = '0, m_po_m = '0;
  bit         m_pov = 1'b0, m_ovr = 1'b0, m_sof = 1'b0;

  always @(posedge clk) begin
    bit done;
    logic [W-1:0] wl, wm;
    done = 1'b0;
    wl = '0;
    wm = '0;
    if (rst) begin
      m_cnt = 0; m_po_l = '0; m_po_m = '0;
      m_pov = 1'b0; m_ovr = 1'b0; m_sof = 1'b0;
    end else begin
      m_sof = 1'b0;
      if (si_valid) begin
        if (si_sof) begin
          m_sof = (m_cnt != 0);
          m_cnt = 0;
        end
        bits[m_cnt] = si;
        m_cnt++;
        if (m_cnt == W) begin
          done = 1'b1;
          m_cnt = 0;
          for (int i = 0; i < W; i++) begin
            wl[i]       = bits[i];
            wm[W-1-i]   = bits[i];
          end
        end
      end
      if (ovr_clr) m_ovr = 1'b0;
      if (done) begin
        if (!m_pov || po_ready) begin
          m_po_l = wl; m_po_m = wm; m_pov = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_pov && po_ready) begin
        m_pov = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("po_l", 32'(if_l.po), 32'(m_po_l));
      chk("po_m", 32'(if_m.po), 32'(m_po_m));
      chk("pov_l", 32'(if_l.po_valid), 32'(m_pov));
      chk("pov_m", 32'(if_m.po_valid), 32'(m_pov));
      chk("busy_l", 32'(busy_l), 32'(m_cnt != 0));
      chk("busy_m", 32'(busy_m), 32'(m_cnt != 0));
      chk("ovr_l", 32'(ovr_l), 32'(m_ovr));
      chk("ovr_m", 32'(ovr_m), 32'(m_ovr));
      chk("sof_l", 32'(sof_l), 32'(m_sof));
      chk("sof_m", 32'(sof_m), 32'(m_sof));
    end
  end

  // One cycle: apply inputs (at a falling edge), pass the rising edge, return at the next falling edge.
  task automatic step(input logic b, input logic v, input logic s, input logic r, input logic c);
    si = b; si_valid = v; si_sof = s; po_ready = r; ovr_clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 1'b0, r, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    idle(1'b0);
    started = 1'b1;
    // Reset state
    chk("rst_po", 32'(if_l.po), 32'h0);
    chk("rst_pov", 32'(if_l.po_valid), 32'h0);
    chk("rst_busy", 32'(busy_l), 32'h0);
    rst = 1'b0;

    // 1/2: single word 1,0,1,1 with SOF, both bit orders
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); chk("t1_busy1", 32'(busy_l), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); chk("t1_busy2", 32'(busy_l), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); chk("t1_busy3", 32'(busy_l), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t1_busy4", 32'(busy_l), 32'h0);
    chk("t1_po_lsb", 32'(if_l.po), 32'hD);
    chk("t2_po_msb", 32'(if_m.po), 32'hB);
    chk("t1_pov", 32'(if_l.po_valid), 32'h1);
    idle(1'b1);
    chk("t1_drained", 32'(if_l.po_valid), 32'h0);

    // 3: gaps and back-pressure, A=1,0,0,1 B=0,1,1,0
    begin
      logic [7:0] s8;
      s8 = 8'b0110_1001;
      for (int i = 0; i < 8; i++) begin
        step(s8[i], 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
      end
    end
    chk("t3_po_held", 32'(if_l.po), 32'h9);
    chk("t3_ovr_set", 32'(ovr_l), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovr_clr", 32'(ovr_l), 32'h0);

    // 4: word 0,1,1,0 with ready only on its completing edge
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_po", 32'(if_l.po), 32'h6);
    chk("t4_pov", 32'(if_l.po_valid), 32'h1);
    chk("t4_ovr", 32'(ovr_l), 32'h0);
    idle(1'b1);

    // 5: realignment, 1,1 then SOF 0,0,1,0
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_soferr", 32'(sof_l), 32'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_soferr_clr", 32'(sof_l), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_po_lsb", 32'(if_l.po), 32'h4);
    chk("t5_po_msb", 32'(if_m.po), 32'h2);

    // Drop and clear on the same edge: the drop wins
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("ovr_set_wins", 32'(ovr_l), 32'h1);

    // 6: mid-word reset while a word is buffered
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    chk("t6_po0", 32'(if_l.po), 32'h0);
    chk("t6_pov0", 32'(if_l.po_valid), 32'h0);
    chk("t6_busy0", 32'(busy_l), 32'h0);
    chk("t6_ovr0", 32'(ovr_l), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_partial", 32'(if_l.po_valid), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_po", 32'(if_l.po), 32'hF);
    chk("t6_pov", 32'(if_l.po_valid), 32'h1);

    // Back-to-back words with ready high: no bubble
    for (int i = 0; i < 8; i++) step(i[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("b2b_po", 32'(if_l.po), 32'h5);
    idle(1'b1);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
